// File: rtl/mood_telem_pkg.sv
// Shared types and constants for the mood telemetry UART.
// MOOD_TELEM_CHECKSUM_EN appends an XOR checksum byte to every frame.
package mood_telem_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef MOOD_TELEM_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif

    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_SEND
    } frame_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; done pulses in the final stop-bit cycle so the
// next byte can be issued with no idle gap.
module uart_tx_byte
    import mood_telem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx      = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_START;
                    sh_d    = data;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx = sh_q[0];
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done  = 1'b1;
                    cnt_d = '0;
                    if (start) begin
                        state_d = S_START;
                        sh_d    = data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/mood_telemetry_uart.sv
// Snapshots mimosa debug state and streams it as a UART frame.
// MOOD_TELEM_CHECKSUM_EN adds a trailing XOR byte over bytes 1..4.
module mood_telemetry_uart
    import mood_telem_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int FRAME_INTERVAL = 10000000,
    parameter int DROP_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              send_now,
    input  logic [6:0]        dbg_energy,
    input  logic [6:0]        dbg_stress,
    input  logic [6:0]        dbg_pleasure,
    input  logic [7:0]        mood,
    output logic              uart_tx,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int IW = $clog2(FRAME_INTERVAL);

    frame_state_e      fstate_q, fstate_d;
    logic [IW-1:0]     ivl_q, ivl_d;
    logic [IDX_W-1:0]  idx_q, idx_d, ser_idx;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [6:0]        energy_q, stress_q, pleasure_q;
    logic [7:0]        mood_q, ser_data;
    logic              tick, trigger, capture, ser_start, ser_done;

    assign tick     = enable && (ivl_q == IW'(FRAME_INTERVAL - 1));
    assign trigger  = tick || send_now;
    assign busy     = (fstate_q != F_IDLE);
    assign capture  = trigger && !busy;
    assign drop_cnt = drop_q;

    always_comb begin
        ivl_d = ivl_q + IW'(1);
        if (!enable || tick) ivl_d = '0;
        drop_d = drop_q;
        if (trigger && busy && drop_q != {DROP_W{1'b1}})
            drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q    <= F_IDLE;
            ivl_q       <= '0;
            idx_q       <= '0;
            drop_q      <= '0;
            energy_q    <= '0;
            stress_q    <= '0;
            pleasure_q  <= '0;
            mood_q      <= '0;
        end else begin
            fstate_q <= fstate_d;
            ivl_q    <= ivl_d;
            idx_q    <= idx_d;
            drop_q   <= drop_d;
            if (capture) begin
                energy_q   <= dbg_energy;
                stress_q   <= dbg_stress;
                pleasure_q <= dbg_pleasure;
                mood_q     <= mood;
            end
        end
    end

    // Next byte is chosen from idx+1 on done so it starts back to back.
    always_comb begin
        fstate_d  = fstate_q;
        idx_d     = idx_q;
        ser_idx   = idx_q;
        ser_start = 1'b0;
        case (fstate_q)
            F_IDLE: begin
                idx_d = '0;
                if (trigger) fstate_d = F_LOAD;
            end
            F_LOAD: begin
                ser_start = 1'b1;
                fstate_d  = F_SEND;
            end
            F_SEND: begin
                if (ser_done) begin
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        fstate_d = F_IDLE;
                    end else begin
                        ser_idx   = idx_q + IDX_W'(1);
                        idx_d     = ser_idx;
                        ser_start = 1'b1;
                    end
                end
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    always_comb begin
        case (ser_idx)
            3'd1:    ser_data = {1'b0, energy_q};
            3'd2:    ser_data = {1'b0, stress_q};
            3'd3:    ser_data = {1'b0, pleasure_q};
            3'd4:    ser_data = mood_q;
`ifdef MOOD_TELEM_CHECKSUM_EN
            3'd5:    ser_data = {1'b0, energy_q ^ stress_q ^ pleasure_q}
                              ^ mood_q;
`endif
            default: ser_data = SYNC_BYTE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ser_start),
        .data  (ser_data),
        .tx    (uart_tx),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_mood_telemetry_uart.sv
// Scoreboard bench: stimulus queues expected frame bytes, a UART
// receiver monitor decodes uart_tx and compares against the queue.
module tb_mood_telemetry_uart;
    import mood_telem_pkg::*;

    localparam int CPB = 4;
    localparam int FI  = 400;
    localparam int DW  = 8;
    localparam int FRAME_BUSY = NBYTES * 10 * CPB + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          send_now = 1'b0;
    logic [6:0]    e_i = '0, s_i = '0, p_i = '0;
    logic [7:0]    m_i = '0;
    logic          tx, busy;
    logic [DW-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    mood_telemetry_uart #(
        .CLKS_PER_BIT  (CPB),
        .FRAME_INTERVAL(FI),
        .DROP_W        (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .send_now    (send_now),
        .dbg_energy  (e_i),
        .dbg_stress  (s_i),
        .dbg_pleasure(p_i),
        .mood        (m_i),
        .uart_tx     (tx),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [6:0] e, input logic [6:0] s,
                              input logic [6:0] p, input logic [7:0] m);
        exp_q.push_back(8'hA5);
        exp_q.push_back({1'b0, e});
        exp_q.push_back({1'b0, s});
        exp_q.push_back({1'b0, p});
        exp_q.push_back(m);
        if (NBYTES == 6)
            exp_q.push_back({1'b0, e} ^ {1'b0, s} ^ {1'b0, p} ^ m);
    endtask

    // Call at a negedge with busy low; returns at the negedge after T.
    task automatic fire(input logic [6:0] e, input logic [6:0] s,
                        input logic [6:0] p, input logic [7:0] m);
        e_i = e; s_i = s; p_i = p; m_i = m;
        send_now = 1'b1;
        push_frame(e, s, p, m);
        @(negedge clk);
        send_now = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_rise(output int t);
        int k = 0;
        while (!busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        t = cyc_n;
        chk("wait_rise", busy, 1);
    endtask

    // UART receiver: samples each bit mid-way, checks start/stop framing.
    int         mon_c = 0;
    logic       mon_act = 1'b0;
    logic [9:0] mon_bits;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_c   = 0;
            end
        end else begin
            mon_c++;
            if (mon_c % CPB == CPB / 2)
                mon_bits[mon_c / CPB] = tx;
            if (mon_c == 9 * CPB + CPB / 2) begin
                mon_act = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h expected none",
                             mon_bits[8:1]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("rx_byte", {22'd0, mon_bits},
                        {22'd0, 1'b1, mon_exp, 1'b0});
                end
            end
        end
    end

    int   blen;
    int   r1, r2;
    logic bad;

    initial begin
        cyc(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;

        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || drop_cnt !== '0) bad = 1'b1;
        end
        chk("quiet_1000", bad, 0);

        fire(7'h12, 7'h05, 7'h7F, 8'h3C);
        chk("busy_T1", busy, 1);
        chk("tx_T1", tx, 1);
        blen = 1;
        @(negedge clk);
        chk("start_T2", tx, 0);
        while (busy && blen < 2000) begin
            blen++;
            @(negedge clk);
        end
        chk("busy_len", blen, FRAME_BUSY);

        fire(7'h01, 7'h02, 7'h03, 8'hAA);
        e_i = 7'h7E; s_i = 7'h6D; p_i = 7'h5C; m_i = 8'h4B;
        cyc(30);
        e_i = 7'h00; s_i = 7'h11; p_i = 7'h22; m_i = 8'hFF;
        wait_idle();
        chk("drop_zero", drop_cnt, 0);

        e_i = 7'h33; s_i = 7'h44; p_i = 7'h55; m_i = 8'h66;
        push_frame(7'h33, 7'h44, 7'h55, 8'h66);
        push_frame(7'h33, 7'h44, 7'h55, 8'h66);
        enable = 1'b1;
        wait_rise(r1);
        cyc(50);
        e_i = 7'h0F; s_i = 7'h70; p_i = 7'h01; m_i = 8'h99;
        send_now = 1'b1;
        @(negedge clk);
        send_now = 1'b0;
        e_i = 7'h33; s_i = 7'h44; p_i = 7'h55; m_i = 8'h66;
        wait_idle();
        chk("drop_one", drop_cnt, 1);
        wait_rise(r2);
        enable = 1'b0;
        chk("period", r2 - r1, FI);
        wait_idle();
        chk("drop_still_one", drop_cnt, 1);

        for (int f = 0; f < 2; f++) begin
            fire(7'h4A, 7'h3B, 7'h2C, 8'h1D);
            for (int k = 0; busy && k < 1000; k++) begin
                send_now = 1'b1;
                @(negedge clk);
                send_now = 1'b0;
            end
            if (f == 0) chk("drop_mid", drop_cnt, 1 + FRAME_BUSY);
        end
        chk("drop_sat", drop_cnt, 255);

        fire(7'h2A, 7'h15, 7'h40, 8'hC3);
        cyc(10);
        chk("pre_rst_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        exp_q.delete();
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        fire(7'h6B, 7'h1E, 7'h33, 8'h81);
        wait_idle();
        cyc(5);
        chk("queue_empty", exp_q.size(), 0);
        chk("final_drop", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
